// File: rtl/serial_arith_pkg.sv
// Shared types and constants for the bit-serial arithmetic blocks.
// Holds the FSM state encoding and the counter-width helper.
package serial_arith_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 4;

  function automatic int cnt_width(input int w);
    return ($clog2(w) < 1) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/serial_fa.sv
// One-bit combinational full-adder cell.
// The carry register belongs to whichever serial block uses it.
module serial_fa (
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = x ^ y ^ cin;
  assign cout = (x & y) | (x & cin) | (y & cin);

endmodule

// File: rtl/serial_sub4.sv
// Bit-serial subtractor: diff = a - b, computed as a + ~b + 1, LSB first.
// Operands load in parallel; the result is published with a done pulse.
module serial_sub4
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             zero
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state;
  state_t           state_n;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] d_sh;
  logic [CW-1:0]    cnt;
  logic             c;
  logic             fa_s;
  logic             fa_cout;
  logic             last;

  serial_fa u_fa (
    .x    (a_sh[0]),
    .y    (b_sh[0]),
    .cin  (c),
    .s    (fa_s),
    .cout (fa_cout)
  );

  assign last = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (start) state_n = SHIFT;
      SHIFT:   if (last) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      d_sh   <= '0;
      cnt    <= '0;
      c      <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      diff   <= '0;
      borrow <= 1'b0;
      zero   <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            a_sh <= a;
            b_sh <= ~b;
            c    <= 1'b1;
            cnt  <= '0;
            busy <= 1'b1;
          end
        end
        SHIFT: begin
          c    <= fa_cout;
          d_sh <= {fa_s, d_sh[WIDTH-1:1]};
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          cnt  <= cnt + CW'(1);
        end
        DONE: begin
          // final carry-out of a + ~b + 1 is 1 exactly when no borrow
          diff   <= d_sh;
          borrow <= ~c;
          zero   <= (d_sh == '0);
          done   <= 1'b1;
          busy   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
